alu_cmd_issuer: RTL



---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_cmd_issuer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, state encoding and flag layout for the ALU command issuer
package alu_pkg;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_NOT     = 4'b0010;
    localparam logic [3:0] OP_NOR     = 4'b0011;
    localparam logic [3:0] OP_XOR     = 4'b0100;
    localparam logic [3:0] OP_NAND    = 4'b0101;
    localparam logic [3:0] OP_ADD     = 4'b0110;
    localparam logic [3:0] OP_SUB     = 4'b0111;
    localparam logic [3:0] OP_ABSDIFF = 4'b1000;
    localparam logic [3:0] OP_MUL     = 4'b1001;
    localparam logic [3:0] OP_SHL     = 4'b1010;
    localparam logic [3:0] OP_SHLA    = 4'b1011;
    localparam logic [3:0] OP_SHR     = 4'b1100;
    localparam logic [3:0] OP_SHRA    = 4'b1101;

    // Bit positions inside rsp_flags = {cout, negative, zero, overflow}
    localparam int FLAG_OVF  = 0;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_NEG  = 2;
    localparam int FLAG_COUT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Codes 1110 and 1111 have no ALU operation behind them
    function automatic logic is_legal_op(input logic [3:0] sel);
        return sel <= OP_SHRA;
    endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - handshake front-end that drives the external ALU and returns its result
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic             cmd_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_y,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_sel,
    output logic             alu_cin,
    input  logic [31:0]      alu_y,
    input  logic             alu_cout,
    input  logic             alu_neg,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

    state_t state_q;
    state_t state_d;

    logic   cmd_legal;
    logic   cmd_accept;
    logic   rsp_consume;
    logic   capture;
    logic [3:0] alu_flags;

    assign cmd_legal   = is_legal_op(cmd_sel);
    assign cmd_accept  = cmd_valid & cmd_ready;
    assign rsp_consume = rsp_valid & rsp_ready;
    assign capture     = (state_q == ST_ISSUE);

    always_comb begin
        alu_flags            = 4'b0000;
        alu_flags[FLAG_COUT] = alu_cout;
        alu_flags[FLAG_NEG]  = alu_neg;
        alu_flags[FLAG_ZERO] = alu_zero;
        alu_flags[FLAG_OVF]  = alu_ovf;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; RESP can consume and accept in one cycle
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = cmd_legal ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                cmd_ready = rsp_ready;
                if (rsp_ready) begin
                    if (cmd_valid) begin
                        state_d = cmd_legal ? ST_ISSUE : ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ALU input registers change only on a legal accept and hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            alu_cin <= 1'b0;
        end else if (cmd_accept && cmd_legal) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
            alu_cin <= cmd_cin;
        end
    end

    // Response registers: error response on illegal accept, ALU capture after ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_y     <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else if (capture) begin
            rsp_y     <= alu_y;
            rsp_flags <= alu_flags;
            rsp_err   <= 1'b0;
        end else if (cmd_accept && !cmd_legal) begin
            rsp_y     <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b1;
        end
    end

    // Sticky overflow; a capture with overflow beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
        end else if (capture && alu_ovf) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

    // Completed-response counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (rsp_consume) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
